hazard_pipe_ctrl: RTL and testbench
===================================

# hazard_pipe_ctrl

Register-index and control-bit pipeline for the EX, MEM and WB stages, with load-use hazard detection and bubble/flush insertion. It sits between decode and the forwarding logic. It captures the decoded source/destination indices and write/load flags each cycle and shifts them through ID/EX, EX/MEM and MEM/WB. It supplies the EX-stage sources and the MEM/WB destinations that the forwarding unit compares. It also raises `stall` to freeze PC and IF/ID when a load result is needed one cycle too early.

## Interface
- `REG_W`, 5: register index width; index `{REG_W{1'b1}}` (X31/XZR) is never a hazard source.
- `CNT_W`, 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ID_Rn`  in  REG_W  decoded first source index.
- `ID_Rm`  in  REG_W  decoded second source index.
- `ID_Rd`  in  REG_W  decoded destination index.
- `ID_UseRn`, `ID_UseRm`  in  1  the instruction actually reads Rn / Rm. An immediate form has `ID_UseRm`=0.
- `ID_RegWrite`  in  1  instruction writes Rd.
- `ID_MemRead`  in  1  instruction is a load.
- `flush`  in  1  taken branch resolved; squash the instruction in ID.
- `EX_Rn`, `EX_Rm`, `EX_Rd`  out  REG_W  ID/EX register contents.
- `EX_RegWrite`, `EX_MemRead`  out  1  ID/EX control bits.
- `MEM_Rd`  out  REG_W  EX/MEM destination.
- `MEM_RegWrite`  out  1  EX/MEM write flag.
- `WB_Rd`  out  REG_W  MEM/WB destination.
- `WB_RegWrite`  out  1  MEM/WB write flag.
- `stall`  out  1  combinational; 1 means hold PC and IF/ID.
- `stall_count`  out  CNT_W  number of cycles with `stall`=1 since reset, saturating.

## Operation
- **Bubble** means: Rn=Rm=Rd=all-ones (31), RegWrite=0, MemRead=0.
- **Hazard condition** `haz` is true when all of the following hold:
  - `EX_MemRead`=1, and
  - `EX_Rd`≠31, and
  - (`ID_UseRn` and `ID_Rn`=`EX_Rd`) or (`ID_UseRm` and `ID_Rm`=`EX_Rd`).
- `stall` = `haz` and not `flush`. A flush overrides the stall because the dependent instruction is discarded anyway.
- **ID/EX next value:**
  - Bubble if `flush` or `haz`.
  - Otherwise the ID inputs, except that `ID_Rn` is replaced by 31 when `ID_UseRn`=0, and likewise for `ID_Rm`. This prevents false forwarding.
- **EX/MEM next value:** `MEM_Rd`←`EX_Rd` and `MEM_RegWrite`←`EX_RegWrite`, every cycle, unconditionally.
- **MEM/WB next value:** `WB_Rd`←`MEM_Rd` and `WB_RegWrite`←`MEM_RegWrite`, every cycle, unconditionally.
- **Stall counter:** increments by 1 on each edge where `stall`=1. It holds at all-ones and never wraps.
- **Destination 31:** `ID_RegWrite`=1 with `ID_Rd`=31 propagates unchanged. The forwarding unit masks X31 on its side. This block masks X31 only for hazard detection.
- A load whose Rd matches only an unused source (`ID_UseRm`=0 and `ID_Rm`=`EX_Rd`) does not stall.

## Timing
- **Reset** (edge with `reset`=1):
  - All three stage registers load bubble, so `EX_/MEM_/WB_` Rd/Rn/Rm = 31 and all flags = 0.
  - `stall_count` = 0.
  - `stall` evaluates to 0 at the first edge after reset because `EX_MemRead`=0.
  - Reset has priority over `flush` and `haz`.
- **Reset mid-operation:** any in-flight instruction is discarded on that edge. There is no partial shift.
- **Latency:**
  - An instruction's Rd appears on `EX_Rd` 1 cycle after capture, on `MEM_Rd` after 2, and on `WB_Rd` after 3.
- **Load-use sequence:**
  - Cycle N: load sits in EX, dependent instruction in ID, so `stall`=1.
  - Edge N: bubble enters ID/EX, load moves to MEM, and the ID inputs remain unchanged because upstream held them.
  - Cycle N+1: `stall`=0. The dependency is now a MEM/WB forward.
  - Exactly one stall cycle per load-use pair.
- **Back-to-back loads:** consecutive dependent loads each stall one cycle.
- **`flush` and `haz` in the same cycle:** `stall`=0, ID/EX gets a bubble, and the counter does not increment.
- `stall` is purely combinational from the ID inputs and ID/EX state. No registered outputs depend on the current-cycle `flush`, except through the next-edge ID/EX load.

## Test plan
- **Reset:** assert `reset` for 2 cycles with arbitrary ID inputs → `EX_Rd`=`MEM_Rd`=`WB_Rd`=31, all flags 0, `stall`=0, `stall_count`=0.
- **Plain pipeline:** ADD Rd=3 (`RegWrite`=1) issued at cycle 0, followed by NOPs → `EX_Rd`=3 at cycle 1, `MEM_Rd`=3 with `MEM_RegWrite`=1 at cycle 2, `WB_Rd`=3 at cycle 3, with no stall.
- **Load-use:** LDUR X5 followed by ADD Rn=5, Rm=7 → `stall`=1 for exactly one cycle. The next `EX_Rd`/`EX_RegWrite` is bubble (31/0), then the ADD enters EX, and `stall_count`=1.
- **No false stall:**
  - LDUR X5 followed by ADDI Rn=2 with `ID_Rm`=5 and `ID_UseRm`=0 → `stall`=0, and `EX_Rm`=31 on the next cycle.
  - LDUR XZR (Rd=31) followed by a use of 31 → `stall`=0.
- **Flush priority:** load in EX plus a dependent instruction in ID with `flush`=1 → `stall`=0, ID/EX gets a bubble, and `stall_count` is unchanged.
- **Counter saturation:** with `CNT_W`=2, force 5 load-use stalls → `stall_count` = 3 and stays at 3.

Source files
------------

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: ID/EX, EX/MEM, MEM/WB index/control pipeline with load-use stall and flush bubbles
module hazard_pipe_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_Rn,
    input  logic [REG_W-1:0] ID_Rm,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_UseRn,
    input  logic             ID_UseRm,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             flush,
    output logic [REG_W-1:0] EX_Rn,
    output logic [REG_W-1:0] EX_Rm,
    output logic [REG_W-1:0] EX_Rd,
    output logic             EX_RegWrite,
    output logic             EX_MemRead,
    output logic [REG_W-1:0] MEM_Rd,
    output logic             MEM_RegWrite,
    output logic [REG_W-1:0] WB_Rd,
    output logic             WB_RegWrite,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [REG_W-1:0] ZR = '1;
    logic haz, bub;
    assign haz = EX_MemRead && EX_Rd != ZR &&
                 ((ID_UseRn && ID_Rn == EX_Rd) || (ID_UseRm && ID_Rm == EX_Rd));
    assign stall = haz && !flush;
    assign bub = flush || haz;
    always_ff @(posedge clk) begin
        if (reset) begin
            EX_Rn        <= ZR;
            EX_Rm        <= ZR;
            EX_Rd        <= ZR;
            EX_RegWrite  <= 1'b0;
            EX_MemRead   <= 1'b0;
            MEM_Rd       <= ZR;
            MEM_RegWrite <= 1'b0;
            WB_Rd        <= ZR;
            WB_RegWrite  <= 1'b0;
            stall_count  <= '0;
        end else begin
            EX_Rn        <= (bub || !ID_UseRn) ? ZR : ID_Rn;
            EX_Rm        <= (bub || !ID_UseRm) ? ZR : ID_Rm;
            EX_Rd        <= bub ? ZR : ID_Rd;
            EX_RegWrite  <= !bub && ID_RegWrite;
            EX_MemRead   <= !bub && ID_MemRead;
            MEM_Rd       <= EX_Rd;
            MEM_RegWrite <= EX_RegWrite;
            WB_Rd        <= MEM_Rd;
            WB_RegWrite  <= MEM_RegWrite;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb_hazard_pipe_ctrl: directed table-driven bench for hazard_pipe_ctrl
module tb_hazard_pipe_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic [4:0] ID_Rn, ID_Rm, ID_Rd;
    logic ID_UseRn, ID_UseRm, ID_RegWrite, ID_MemRead, flush;
    logic [4:0] EX_Rn, EX_Rm, EX_Rd, MEM_Rd, WB_Rd;
    logic EX_RegWrite, EX_MemRead, MEM_RegWrite, WB_RegWrite, stall;
    logic [15:0] stall_count;
    logic [4:0] s_EX_Rn, s_EX_Rm, s_EX_Rd, s_MEM_Rd, s_WB_Rd;
    logic s_EX_RegWrite, s_EX_MemRead, s_MEM_RegWrite, s_WB_RegWrite, s_stall;
    logic [1:0] s_stall_count;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    hazard_pipe_ctrl dut (
        .clk(clk), .reset(reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_UseRn(ID_UseRn), .ID_UseRm(ID_UseRm), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .flush(flush), .EX_Rn(EX_Rn), .EX_Rm(EX_Rm),
        .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .WB_Rd(WB_Rd),
        .WB_RegWrite(WB_RegWrite), .stall(stall), .stall_count(stall_count)
    );

    hazard_pipe_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_UseRn(ID_UseRn), .ID_UseRm(ID_UseRm), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .flush(flush), .EX_Rn(s_EX_Rn), .EX_Rm(s_EX_Rm),
        .EX_Rd(s_EX_Rd), .EX_RegWrite(s_EX_RegWrite), .EX_MemRead(s_EX_MemRead),
        .MEM_Rd(s_MEM_Rd), .MEM_RegWrite(s_MEM_RegWrite), .WB_Rd(s_WB_Rd),
        .WB_RegWrite(s_WB_RegWrite), .stall(s_stall), .stall_count(s_stall_count)
    );

    typedef struct {
        int rn, rm, rd, urn, urm, rw, mr, fl;
        int st;
        int erd, ern, erm, erw, emr, mrd, mrw, wrd, wrw, cnt;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", n, a, e);
        end
    endtask

    task automatic drive(input int rn, rm, rd, urn, urm, rw, mr, fl);
        ID_Rn = 5'(rn); ID_Rm = 5'(rm); ID_Rd = 5'(rd);
        ID_UseRn = 1'(urn); ID_UseRm = 1'(urm);
        ID_RegWrite = 1'(rw); ID_MemRead = 1'(mr); flush = 1'(fl);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string t);
        chk({t, " EX_Rd"}, int'(EX_Rd), 31);
        chk({t, " EX_Rn"}, int'(EX_Rn), 31);
        chk({t, " EX_Rm"}, int'(EX_Rm), 31);
        chk({t, " EX_RegWrite"}, int'(EX_RegWrite), 0);
        chk({t, " EX_MemRead"}, int'(EX_MemRead), 0);
        chk({t, " MEM_Rd"}, int'(MEM_Rd), 31);
        chk({t, " MEM_RegWrite"}, int'(MEM_RegWrite), 0);
        chk({t, " WB_Rd"}, int'(WB_Rd), 31);
        chk({t, " WB_RegWrite"}, int'(WB_RegWrite), 0);
        chk({t, " stall"}, int'(stall), 0);
        chk({t, " stall_count"}, int'(stall_count), 0);
        chk({t, " sat stall_count"}, int'(s_stall_count), 0);
    endtask

    initial begin
        //        rn  rm  rd urn urm rw mr fl  st  erd ern erm erw emr mrd mrw wrd wrw cnt
        tbl[0]  = '{1,  2,  3, 1, 1, 1, 0, 0,  0,  3,  1,  2,  1, 0, 31, 0, 31, 0, 0};
        tbl[1]  = '{31, 31, 31, 0, 0, 0, 0, 0,  0,  31, 31, 31, 0, 0, 3,  1, 31, 0, 0};
        tbl[2]  = '{31, 31, 31, 0, 0, 0, 0, 0,  0,  31, 31, 31, 0, 0, 31, 0, 3,  1, 0};
        tbl[3]  = '{1,  31, 5, 1, 0, 1, 1, 0,  0,  5,  1,  31, 1, 1, 31, 0, 31, 0, 0};
        tbl[4]  = '{5,  7,  8, 1, 1, 1, 0, 0,  1,  31, 31, 31, 0, 0, 5,  1, 31, 0, 1};
        tbl[5]  = '{5,  7,  8, 1, 1, 1, 0, 0,  0,  8,  5,  7,  1, 0, 31, 0, 5,  1, 1};
        tbl[6]  = '{1,  31, 5, 1, 0, 1, 1, 0,  0,  5,  1,  31, 1, 1, 8,  1, 31, 0, 1};
        tbl[7]  = '{2,  5,  9, 1, 0, 1, 0, 0,  0,  9,  2,  31, 1, 0, 5,  1, 8,  1, 1};
        tbl[8]  = '{1,  31, 31, 1, 0, 1, 1, 0, 0,  31, 1,  31, 1, 1, 9,  1, 5,  1, 1};
        tbl[9]  = '{31, 31, 4, 1, 1, 1, 0, 0,  0,  4,  31, 31, 1, 0, 31, 1, 9,  1, 1};
        tbl[10] = '{1,  31, 6, 1, 0, 1, 1, 0,  0,  6,  1,  31, 1, 1, 4,  1, 31, 1, 1};
        tbl[11] = '{2,  6, 10, 1, 1, 1, 0, 1,  0,  31, 31, 31, 0, 0, 6,  1, 4,  1, 1};
        tbl[12] = '{1,  31, 7, 1, 0, 1, 1, 0,  0,  7,  1,  31, 1, 1, 31, 0, 6,  1, 1};
        tbl[13] = '{7,  31, 8, 1, 0, 1, 1, 0,  1,  31, 31, 31, 0, 0, 7,  1, 31, 0, 2};
        tbl[14] = '{7,  31, 8, 1, 0, 1, 1, 0,  0,  8,  7,  31, 1, 1, 31, 0, 7,  1, 2};
        tbl[15] = '{8,  8, 11, 1, 1, 1, 0, 0,  1,  31, 31, 31, 0, 0, 8,  1, 31, 0, 3};
        tbl[16] = '{8,  8, 11, 1, 1, 1, 0, 0,  0,  11, 8,  8,  1, 0, 31, 0, 8,  1, 3};

        reset = 1'b1;
        drive(5, 5, 5, 1, 1, 1, 1, 1);
        step();
        step();
        chk_bubble("reset");
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rn, tbl[i].rm, tbl[i].rd, tbl[i].urn, tbl[i].urm,
                  tbl[i].rw, tbl[i].mr, tbl[i].fl);
            chk($sformatf("v%0d stall", i), int'(stall), tbl[i].st);
            step();
            chk($sformatf("v%0d EX_Rd", i), int'(EX_Rd), tbl[i].erd);
            chk($sformatf("v%0d EX_Rn", i), int'(EX_Rn), tbl[i].ern);
            chk($sformatf("v%0d EX_Rm", i), int'(EX_Rm), tbl[i].erm);
            chk($sformatf("v%0d EX_RegWrite", i), int'(EX_RegWrite), tbl[i].erw);
            chk($sformatf("v%0d EX_MemRead", i), int'(EX_MemRead), tbl[i].emr);
            chk($sformatf("v%0d MEM_Rd", i), int'(MEM_Rd), tbl[i].mrd);
            chk($sformatf("v%0d MEM_RegWrite", i), int'(MEM_RegWrite), tbl[i].mrw);
            chk($sformatf("v%0d WB_Rd", i), int'(WB_Rd), tbl[i].wrd);
            chk($sformatf("v%0d WB_RegWrite", i), int'(WB_RegWrite), tbl[i].wrw);
            chk($sformatf("v%0d stall_count", i), int'(stall_count), tbl[i].cnt);
        end

        // reset mid-operation with a load in flight and a dependent instruction in ID
        drive(1, 31, 5, 1, 0, 1, 1, 0);
        step();
        drive(5, 7, 8, 1, 1, 1, 0, 0);
        chk("midreset pre stall", int'(stall), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_bubble("midreset");

        // saturation: five load-use pairs
        for (int i = 0; i < 5; i++) begin
            drive(1, 31, 5, 1, 0, 1, 1, 0);
            chk($sformatf("sat%0d load stall", i), int'(stall), 0);
            step();
            drive(5, 7, 8, 1, 1, 1, 0, 0);
            chk($sformatf("sat%0d use stall", i), int'(stall), 1);
            step();
            chk($sformatf("sat%0d held stall", i), int'(stall), 0);
            step();
            chk($sformatf("sat%0d count16", i), int'(stall_count), i + 1);
            chk($sformatf("sat%0d count2", i), int'(s_stall_count), (i + 1 > 3) ? 3 : i + 1);
        end
        drive(31, 31, 31, 0, 0, 0, 0, 0);
        step();
        step();
        chk("sat hold count2", int'(s_stall_count), 3);
        chk("sat hold count16", int'(stall_count), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
